// File: rtl/cnn_demux_pkg.sv
// Shared constants, mode encodings and clog2 helper for the CNN stream demux.
package cnn_demux_pkg;

   localparam int DEMUX_DATA_W = 16;
   localparam int DEMUX_NUM_CH = 29;

   typedef enum logic {
      MODE_EXPLICIT = 1'b0,
      MODE_AUTO     = 1'b1
   } demux_mode_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Round-robin channel pointer with a burst counter; advances after BURST_LEN steps.
module demux_rr_ptr
   import cnn_demux_pkg::*;
#(
   parameter int NUM_CH    = DEMUX_NUM_CH,
   parameter int BURST_LEN = 1,
   localparam int SEL_W    = clog2(NUM_CH),
   localparam int BURST_W  = clog2(BURST_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_i,
   input  logic             clr_i,
   output logic [SEL_W-1:0] ptr_o
);

   localparam logic [SEL_W-1:0]   LAST_PTR   = SEL_W'(NUM_CH - 1);
   localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(BURST_LEN - 1);

   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [BURST_W-1:0] cnt_q, cnt_d;

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      // Clear has priority over a simultaneous step.
      if (clr_i) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (step_i) begin
         if (cnt_q == LAST_BURST) begin
            cnt_d = '0;
            ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-NUM_CH stream demux with explicit / round-robin routing.
// Optional broadcast to all channels when DEMUX_BCAST_EN is defined.
module stream_demux_n
   import cnn_demux_pkg::*;
#(
   parameter int DATA_W    = DEMUX_DATA_W,
   parameter int NUM_CH    = DEMUX_NUM_CH,
   parameter int BURST_LEN = 1,
   localparam int SEL_W    = clog2(NUM_CH),
   localparam int BURST_W  = clog2(BURST_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [SEL_W-1:0]  sel,
   input  logic              auto_mode,
   input  logic              ptr_clr,
`ifdef DEMUX_BCAST_EN
   input  logic              bcast,
`endif
   output logic [DATA_W-1:0] dout_data,
   output logic [NUM_CH-1:0] dout_valid,
   input  logic [NUM_CH-1:0] dout_ready,
   output logic [SEL_W-1:0]  cur_ptr,
   output logic              err_oor
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

   demux_mode_e       mode;
   logic              is_bcast;
   logic              acc;
   logic              sel_oor;
   logic              ptr_step;
   logic [SEL_W-1:0]  tgt;
   logic [NUM_CH-1:0] remain;
   logic [NUM_CH-1:0] onehot;
   logic [NUM_CH-1:0] slot_q, slot_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;

`ifdef DEMUX_BCAST_EN
   assign is_bcast = bcast;
`else
   assign is_bcast = 1'b0;
`endif

   assign mode = demux_mode_e'(auto_mode);

   // Channels still owed the held word after this cycle's transfers.
   assign remain    = slot_q & ~dout_ready;
   assign din_ready = ~reset & ~(|remain);
   assign acc       = din_valid & din_ready;

   assign sel_oor  = (mode == MODE_EXPLICIT) & ~is_bcast & (sel > LAST_SEL);
   assign ptr_step = acc & (mode == MODE_AUTO) & ~is_bcast;
   assign tgt      = (mode == MODE_AUTO) ? cur_ptr : sel;

   demux_rr_ptr #(
      .NUM_CH    (NUM_CH),
      .BURST_LEN (BURST_LEN)
   ) u_rr_ptr (
      .clk    (clk),
      .reset  (reset),
      .step_i (ptr_step),
      .clr_i  (ptr_clr),
      .ptr_o  (cur_ptr)
   );

   always_comb begin
      onehot = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         onehot[k] = (tgt == SEL_W'(k));
      end
      if (is_bcast) begin
         onehot = '1;
      end
   end

   always_comb begin
      slot_d = remain;
      data_d = data_q;
      err_d  = 1'b0;
      if (acc) begin
         if (sel_oor) begin
            err_d = 1'b1;
         end else begin
            slot_d = onehot;
            data_d = din;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         slot_q <= slot_d;
         data_q <= data_d;
         err_q  <= err_d;
      end
   end

   assign dout_valid = slot_q;
   assign dout_data  = data_q;
   assign err_oor    = err_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed self-checking bench for stream_demux_n (NUM_CH=29, BURST_LEN=2).
module tb_stream_demux_n;
   import cnn_demux_pkg::*;

   localparam int NCH = 29;
   localparam int DW  = 16;
   localparam int SW  = 5;
   localparam logic [NCH-1:0] ALL = {NCH{1'b1}};

   logic           clk = 1'b0;
   logic           reset;
   logic [DW-1:0]  din;
   logic           din_valid;
   logic           din_ready;
   logic [SW-1:0]  sel;
   logic           auto_mode;
   logic           ptr_clr;
   logic           bcast;
   logic [DW-1:0]  dout_data;
   logic [NCH-1:0] dout_valid;
   logic [NCH-1:0] dout_ready;
   logic [SW-1:0]  cur_ptr;
   logic           err_oor;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stream_demux_n #(
      .DATA_W    (DW),
      .NUM_CH    (NCH),
      .BURST_LEN (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .sel        (sel),
      .auto_mode  (auto_mode),
      .ptr_clr    (ptr_clr),
`ifdef DEMUX_BCAST_EN
      .bcast      (bcast),
`endif
      .dout_data  (dout_data),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .cur_ptr    (cur_ptr),
      .err_oor    (err_oor)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      sel        = '0;
      auto_mode  = 1'b0;
      ptr_clr    = 1'b0;
      bcast      = 1'b0;
      dout_ready = ALL;

      // reset state
      tick();
      tick();
      check_val("rst_valid", 32'(dout_valid), 32'h0);
      check_val("rst_data",  32'(dout_data),  32'h0);
      check_val("rst_ptr",   32'(cur_ptr),    32'h0);
      check_val("rst_err",   32'(err_oor),    32'h0);
      check_val("rst_ready", 32'(din_ready),  32'h0);
      reset = 1'b0;
      #1;
      check_val("post_rst_ready", 32'(din_ready), 32'h1);

      // explicit routing, back-to-back
      din_valid = 1'b1;
      for (int s = 0; s < NCH; s++) begin
         sel = SW'(s);
         din = DW'(s + 100);
         #1;
         check_val("expl_ready", 32'(din_ready), 32'h1);
         tick();
         check_val("expl_valid", 32'(dout_valid), 32'h1 << s);
         check_val("expl_data",  32'(dout_data),  32'(s + 100));
      end
      din_valid = 1'b0;
      tick();
      check_val("expl_idle", 32'(dout_valid), 32'h0);

      // out-of-range select
      sel = 5'd29;
      din = 16'h0055;
      din_valid = 1'b1;
      #1;
      check_val("oor_ready", 32'(din_ready), 32'h1);
      tick();
      din_valid = 1'b0;
      check_val("oor_valid", 32'(dout_valid), 32'h0);
      check_val("oor_err",   32'(err_oor),    32'h1);
      check_val("oor_ready_after", 32'(din_ready), 32'h1);
      tick();
      check_val("oor_err_pulse", 32'(err_oor),    32'h0);
      check_val("oor_valid2",    32'(dout_valid), 32'h0);

      // auto mode, burst of 2
      auto_mode = 1'b1;
      sel       = 5'd17;
      din_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         din = DW'(200 + i);
         tick();
         check_val("auto_valid", 32'(dout_valid), 32'h1 << ((i / 2) % NCH));
         check_val("auto_data",  32'(dout_data),  32'(200 + i));
      end
      din_valid = 1'b0;
      check_val("auto_ptr_end", 32'(cur_ptr), 32'h1);
      tick();

      // backpressure on channel 3
      auto_mode     = 1'b0;
      dout_ready[3] = 1'b0;
      sel       = 5'd3;
      din       = 16'h1234;
      din_valid = 1'b1;
      tick();
      sel = 5'd5;
      din = 16'h5678;
      for (int c = 0; c < 5; c++) begin
         check_val("bp_valid", 32'(dout_valid), 32'h1 << 3);
         check_val("bp_data",  32'(dout_data),  32'h1234);
         check_val("bp_ready", 32'(din_ready),  32'h0);
         tick();
      end
      dout_ready[3] = 1'b1;
      #1;
      check_val("bp_release_ready", 32'(din_ready), 32'h1);
      tick();
      din_valid = 1'b0;
      check_val("bp_next_valid", 32'(dout_valid), 32'h1 << 5);
      check_val("bp_next_data",  32'(dout_data),  32'h5678);
      tick();
      check_val("bp_idle", 32'(dout_valid), 32'h0);

      // ptr_clr together with an accept at pointer 7
      ptr_clr = 1'b1;
      tick();
      ptr_clr = 1'b0;
      check_val("clr_ptr0", 32'(cur_ptr), 32'h0);
      auto_mode = 1'b1;
      din_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         din = DW'(i);
         tick();
      end
      check_val("clr_ptr7", 32'(cur_ptr), 32'h7);
      ptr_clr = 1'b1;
      din     = 16'h0077;
      tick();
      ptr_clr   = 1'b0;
      din_valid = 1'b0;
      check_val("clr_word_ch7", 32'(dout_valid), 32'h1 << 7);
      check_val("clr_word_data", 32'(dout_data), 32'h0077);
      check_val("clr_ptr_after", 32'(cur_ptr),   32'h0);
      tick();

      // reset while the slot is full
      auto_mode  = 1'b0;
      dout_ready = '0;
      sel        = 5'd2;
      din        = 16'hBEEF;
      din_valid  = 1'b1;
      tick();
      din_valid = 1'b0;
      check_val("rf_held", 32'(dout_valid), 32'h1 << 2);
      reset = 1'b1;
      tick();
      check_val("rf_valid", 32'(dout_valid), 32'h0);
      check_val("rf_data",  32'(dout_data),  32'h0);
      reset      = 1'b0;
      dout_ready = ALL;
      tick();
      check_val("rf_lost", 32'(dout_valid), 32'h0);

`ifdef DEMUX_BCAST_EN
      // broadcast, channels released one per cycle
      auto_mode = 1'b1;
      din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = DW'(i);
         tick();
      end
      check_val("bc_ptr_before", 32'(cur_ptr), 32'h1);
      bcast = 1'b1;
      din   = 16'h00A5;
      tick();
      check_val("bc_all", 32'(dout_valid), 32'(ALL));
      check_val("bc_ptr_same", 32'(cur_ptr), 32'h1);
      dout_ready = '0;
      bcast     = 1'b0;
      auto_mode = 1'b0;
      sel       = 5'd4;
      din       = 16'h003C;
      for (int k = 0; k < NCH; k++) begin
         dout_ready[k] = 1'b1;
         #1;
         check_val("bc_mask",  32'(dout_valid), 32'((ALL << k) & ALL));
         check_val("bc_data",  32'(dout_data),  32'h00A5);
         check_val("bc_ready", 32'(din_ready),  (k == NCH - 1) ? 32'h1 : 32'h0);
         tick();
      end
      din_valid = 1'b0;
      check_val("bc_next_valid", 32'(dout_valid), 32'h1 << 4);
      check_val("bc_next_data",  32'(dout_data),  32'h003C);
      check_val("bc_ptr_end",    32'(cur_ptr),    32'h1);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
